rx_bram_bank_scheduler: RTL and testbench

//  Sequences the bank of NUM_BANKS rx self-controlled sample BRAMs in the rx chain.
//  On every new-sample trigger:
//   - issues one write enable to the current bank (round-robin);
//   - issues a read sweep of MEMORY_LENGTH consecutive read enables to all banks, feeding the correlator.

---
 rtl/rx_bram_bank_scheduler_pkg.sv | 16 +
 rtl/rx_bram_bank_scheduler_ring_ptr.sv | 50 +++++
 rtl/rx_bram_bank_scheduler.sv | 153 +++++++++++++++
 tb/tb_rx_bram_bank_scheduler.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/rx_bram_bank_scheduler_pkg.sv
// Shared definitions for the rx BRAM bank scheduler: default geometry and FSM state type.
package rx_bram_bank_scheduler_pkg;

    localparam int unsigned RX_NUM_BANKS     = 20;
    localparam int unsigned RX_MEMORY_LENGTH = 510;
    localparam int unsigned RX_BANK_W        = 5;
    localparam int unsigned RX_IDX_W         = 11;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WRITE,
        ST_SWEEP,
        ST_DONE
    } rx_sched_state_t;

endpackage

// File: rtl/rx_bram_bank_scheduler_ring_ptr.sv
// Round-robin bank pointer with wrap, one-hot write decode and sticky "all banks primed" flag.
module rx_bank_ring_ptr
    import rx_bram_bank_scheduler_pkg::*;
#(
    parameter int unsigned NUM_BANKS = RX_NUM_BANKS,
    parameter int unsigned BANK_W    = RX_BANK_W
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_advance,
    output logic [BANK_W-1:0]    o_bank_sel,
    output logic [NUM_BANKS-1:0] o_onehot,
    output logic                 o_primed
);

    localparam logic [BANK_W-1:0] LAST_BANK = BANK_W'(NUM_BANKS - 1);

    logic [BANK_W-1:0] r_ptr;
    logic [BANK_W-1:0] r_last;
    logic              r_primed;
    logic              w_at_last;

    assign w_at_last = (r_ptr == LAST_BANK);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_ptr    <= '0;
            r_last   <= '0;
            r_primed <= 1'b0;
        end else if (i_advance) begin
            r_ptr  <= w_at_last ? '0 : r_ptr + 1'b1;
            r_last <= r_ptr;
            if (w_at_last) begin
                r_primed <= 1'b1;
            end
        end
    end

    always_comb begin
        o_onehot = '0;
        for (int unsigned b = 0; b < NUM_BANKS; b++) begin
            o_onehot[b] = i_advance && (r_ptr == BANK_W'(b));
        end
    end

    // Selected bank and primed flag reflect the write in the very cycle it happens.
    assign o_bank_sel = i_advance ? r_ptr : r_last;
    assign o_primed   = r_primed | (i_advance & w_at_last);

endmodule

// File: rtl/rx_bram_bank_scheduler.sv
// Write/read-sweep sequencer for the rx sample BRAM ring, with overrun detection.
// Optional statistics counters enabled by defining RX_SCHED_STATS_EN.
module rx_bram_bank_scheduler
    import rx_bram_bank_scheduler_pkg::*;
#(
    parameter int unsigned NUM_BANKS     = RX_NUM_BANKS,
    parameter int unsigned MEMORY_LENGTH = RX_MEMORY_LENGTH,
    parameter int unsigned BANK_W        = RX_BANK_W,
    parameter int unsigned IDX_W         = RX_IDX_W
) (
    input  logic                 crx_clk,
    input  logic                 rrx_rst_n,
    input  logic                 erx_en,
    input  logic                 inew_sample_trig,
    output logic [NUM_BANKS-1:0] owr_en_bank,
    output logic                 ord_en,
    output logic [BANK_W-1:0]    obank_sel,
    output logic [IDX_W-1:0]     oread_idx,
    output logic                 osweep_done,
    output logic                 obanks_primed,
    output logic                 ooverrun
`ifdef RX_SCHED_STATS_EN
    ,
    output logic [15:0]          oovr_count,
    output logic [15:0]          osweep_count
`endif
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(MEMORY_LENGTH - 1);

    rx_sched_state_t  r_state;
    rx_sched_state_t  w_next;
    logic [IDX_W-1:0] r_idx;
    logic             r_pending;
    logic             r_overrun;

    logic w_accept;
    logic w_last_rd;
    logic w_write;
    logic w_rd;
    logic w_done;
    logic w_ovr_evt;
    logic w_set_pending;

    assign w_accept  = inew_sample_trig & erx_en;
    assign w_last_rd = (r_idx == LAST_IDX);

    always_comb begin
        w_next        = r_state;
        w_write       = 1'b0;
        w_rd          = 1'b0;
        w_done        = 1'b0;
        w_ovr_evt     = 1'b0;
        w_set_pending = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_next = ST_WRITE;
                end
            end
            ST_WRITE: begin
                w_write = 1'b1;
                w_next  = ST_SWEEP;
                if (w_accept) begin
                    w_ovr_evt = 1'b1;
                    w_next    = ST_WRITE;
                end
            end
            ST_SWEEP: begin
                w_rd = 1'b1;
                if (w_last_rd) begin
                    // A trigger on the final read is legal: finish, pulse done, then write.
                    w_next        = ST_DONE;
                    w_set_pending = w_accept;
                end else if (w_accept) begin
                    w_ovr_evt = 1'b1;
                    w_next    = ST_WRITE;
                end
            end
            ST_DONE: begin
                w_done = 1'b1;
                w_next = (w_accept || r_pending) ? ST_WRITE : ST_IDLE;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge crx_clk or negedge rrx_rst_n) begin
        if (!rrx_rst_n) begin
            r_state   <= ST_IDLE;
            r_idx     <= '0;
            r_pending <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_state <= w_next;
            if (r_state == ST_SWEEP && w_next == ST_SWEEP) begin
                r_idx <= r_idx + 1'b1;
            end else begin
                r_idx <= '0;
            end
            if (w_set_pending) begin
                r_pending <= 1'b1;
            end else if (r_state == ST_DONE) begin
                r_pending <= 1'b0;
            end
            if (w_ovr_evt) begin
                r_overrun <= 1'b1;
            end
        end
    end

    rx_bank_ring_ptr #(
        .NUM_BANKS (NUM_BANKS),
        .BANK_W    (BANK_W)
    ) u_ring_ptr (
        .i_clk      (crx_clk),
        .i_rst_n    (rrx_rst_n),
        .i_advance  (w_write),
        .o_bank_sel (obank_sel),
        .o_onehot   (owr_en_bank),
        .o_primed   (obanks_primed)
    );

    assign ord_en      = w_rd;
    assign oread_idx   = r_idx;
    assign osweep_done = w_done;
    assign ooverrun    = r_overrun;

`ifdef RX_SCHED_STATS_EN
    logic [15:0] r_ovr_count;
    logic [15:0] r_sweep_count;

    always_ff @(posedge crx_clk or negedge rrx_rst_n) begin
        if (!rrx_rst_n) begin
            r_ovr_count   <= '0;
            r_sweep_count <= '0;
        end else begin
            if (w_ovr_evt && (r_ovr_count != '1)) begin
                r_ovr_count <= r_ovr_count + 1'b1;
            end
            if (w_done) begin
                r_sweep_count <= r_sweep_count + 1'b1;
            end
        end
    end

    assign oovr_count   = r_ovr_count;
    assign osweep_count = r_sweep_count;
`endif

endmodule

// File: tb/tb_rx_bram_bank_scheduler.sv
// Self-checking bench: directed + random triggers against a timestamp-based reference model.
module tb_rx_bram_bank_scheduler;
    import rx_bram_bank_scheduler_pkg::*;

    localparam int NB = 20;
    localparam int ML = 510;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          en = 1'b0;
    logic          trig = 1'b0;
    logic [NB-1:0] owr_en_bank;
    logic          ord_en;
    logic [4:0]    obank_sel;
    logic [10:0]   oread_idx;
    logic          osweep_done;
    logic          obanks_primed;
    logic          ooverrun;
`ifdef RX_SCHED_STATS_EN
    logic [15:0]   oovr_count;
    logic [15:0]   osweep_count;
`endif

    rx_bram_bank_scheduler #(
        .NUM_BANKS     (NB),
        .MEMORY_LENGTH (ML),
        .BANK_W        (5),
        .IDX_W         (11)
    ) dut (
        .crx_clk          (clk),
        .rrx_rst_n        (rst_n),
        .erx_en           (en),
        .inew_sample_trig (trig),
        .owr_en_bank      (owr_en_bank),
        .ord_en           (ord_en),
        .obank_sel        (obank_sel),
        .oread_idx        (oread_idx),
        .osweep_done      (osweep_done),
        .obanks_primed    (obanks_primed),
        .ooverrun         (ooverrun)
`ifdef RX_SCHED_STATS_EN
        ,
        .oovr_count       (oovr_count),
        .osweep_count     (osweep_count)
`endif
    );

    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    // Reference model: the schedule is tracked as the cycle number of the latest write.
    longint cyc;
    longint m_tw;
    longint m_newtw;
    int     m_bank;
    int     m_last;
    int     m_writes;
    bit     m_ovr;
    int     m_ovr_cnt;
    int     m_sw_cnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    endtask

    task automatic model_reset();
        m_tw      = -1000000;
        m_newtw   = -1;
        m_bank    = 0;
        m_last    = 0;
        m_writes  = 0;
        m_ovr     = 0;
        m_ovr_cnt = 0;
        m_sw_cnt  = 0;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_wr"}, 32'(owr_en_bank), 32'd0);
        chk({tag, "_rd"}, 32'(ord_en), 32'd0);
        chk({tag, "_sel"}, 32'(obank_sel), 32'd0);
        chk({tag, "_idx"}, 32'(oread_idx), 32'd0);
        chk({tag, "_done"}, 32'(osweep_done), 32'd0);
        chk({tag, "_primed"}, 32'(obanks_primed), 32'd0);
        chk({tag, "_ovr"}, 32'(ooverrun), 32'd0);
`ifdef RX_SCHED_STATS_EN
        chk({tag, "_ovrcnt"}, 32'(oovr_count), 32'd0);
        chk({tag, "_swcnt"}, 32'(osweep_count), 32'd0);
`endif
    endtask

    task automatic step(input bit t, input bit e);
        bit      exp_wr;
        bit      exp_rd;
        bit      exp_done;
        int      exp_idx;
        logic [31:0] exp_onehot;
        int      exp_sel;
        bit      exp_primed;
        @(posedge clk);
        #1;
        trig = t;
        en   = e;
        cyc++;
        @(negedge clk);
        if (cyc == m_newtw) m_tw = m_newtw;
        exp_wr     = (cyc == m_tw);
        exp_rd     = (cyc > m_tw) && (cyc <= m_tw + ML);
        exp_done   = (cyc == m_tw + ML + 1);
        exp_idx    = exp_rd ? int'(cyc - m_tw - 1) : 0;
        exp_onehot = exp_wr ? (32'd1 << m_bank) : 32'd0;
        exp_sel    = exp_wr ? m_bank : m_last;
        exp_primed = (m_writes + int'(exp_wr)) >= NB;

        chk("wr_en_bank", 32'(owr_en_bank), exp_onehot);
        chk("rd_en", 32'(ord_en), 32'(exp_rd));
        if (exp_rd) chk("read_idx", 32'(oread_idx), 32'(exp_idx));
        chk("sweep_done", 32'(osweep_done), 32'(exp_done));
        chk("bank_sel", 32'(obank_sel), 32'(exp_sel));
        chk("primed", 32'(obanks_primed), 32'(exp_primed));
        chk("overrun", 32'(ooverrun), 32'(m_ovr));
        chk("onehot_rd_excl", 32'(($countones(owr_en_bank) <= 1) && !(ord_en && (|owr_en_bank))), 32'd1);
`ifdef RX_SCHED_STATS_EN
        chk("ovr_count", 32'(oovr_count), 32'(m_ovr_cnt));
        chk("sweep_count", 32'(osweep_count), 32'(m_sw_cnt & 16'hFFFF));
`endif

        if (exp_wr) begin
            m_last = m_bank;
            m_bank = (m_bank + 1) % NB;
            m_writes++;
        end
        if (exp_done) m_sw_cnt++;
        if (t && e) begin
            if (cyc >= m_tw && cyc <= m_tw + ML - 1) begin
                m_ovr = 1;
                if (m_ovr_cnt < 65535) m_ovr_cnt++;
            end
            m_newtw = (cyc == m_tw + ML) ? cyc + 2 : cyc + 1;
        end
    endtask

    task automatic idle(input int n, input bit e);
        for (int i = 0; i < n; i++) step(1'b0, e);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        trig  = 1'b0;
        #1;
        check_all_zero("async_reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
    endtask

    initial begin
        cyc = 0;
        model_reset();
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Single trigger, full sweep.
        idle(3, 1'b1);
        step(1'b1, 1'b1);
        idle(600, 1'b1);

        // 21 well-spaced triggers: walk the whole ring and wrap once.
        for (int k = 0; k < 21; k++) begin
            step(1'b1, 1'b1);
            idle(599, 1'b1);
        end

        // Trigger 100 reads into a sweep.
        step(1'b1, 1'b1);
        idle(101, 1'b1);
        step(1'b1, 1'b1);
        idle(600, 1'b1);

        // Trigger exactly on the last read.
        step(1'b1, 1'b1);
        idle(ML, 1'b1);
        step(1'b1, 1'b1);
        idle(600, 1'b1);

        // Trigger during the write cycle and during done.
        step(1'b1, 1'b1);
        step(1'b1, 1'b1);
        idle(ML + 1, 1'b1);
        step(1'b1, 1'b1);
        idle(600, 1'b1);

        // Disabled block ignores triggers; disabling mid-sweep lets the sweep finish.
        for (int i = 0; i < 50; i++) step(1'(i % 3 == 0), 1'b0);
        step(1'b1, 1'b1);
        idle(50, 1'b1);
        for (int i = 0; i < 600; i++) step(1'($urandom_range(0, 20) == 0), 1'b0);

        // Reset mid-sweep.
        step(1'b1, 1'b1);
        idle(60, 1'b1);
        do_reset();
        idle(10, 1'b1);

        // Random triggers, biased towards both quiet and crowded periods.
        for (int i = 0; i < 9000; i++) begin
            bit r_t;
            bit r_e;
            r_e = ($urandom_range(0, 15) != 0);
            if (i % 3000 < 300) r_t = ($urandom_range(0, 60) == 0);
            else r_t = ($urandom_range(0, 400) == 0);
            step(r_t, r_e);
        end
        idle(600, 1'b1);

        // Final mid-sweep reset clears everything, including stats.
        step(1'b1, 1'b1);
        idle(200, 1'b1);
        do_reset();
        idle(5, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
